// File: rtl/fa16_rev_pkg.sv
// Shared types for the fa16_rev compute/uncompute sequencer.
package fa16_rev_pkg;

  localparam int FA16_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    FWD,
    BWD,
    DONE
  } fa16_state_e;

  typedef struct packed {
    logic [FA16_W-1:0] a;
    logic [FA16_W-1:0] b;
    logic              c0;
    logic              z;
  } fa16_opnd_t;

  typedef struct packed {
    logic [FA16_W-1:0] s;
    logic [FA16_W-1:0] a_b;
    logic              c0_b;
    logic              c15;
  } fa16_res_t;

endpackage

// File: rtl/fa16_rev_seq.sv
// Drives one fa16_rev adder forward then backward and checks that the
// original operands are regenerated bit-for-bit.
module fa16_rev_seq
  import fa16_rev_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FA16_W-1:0] in_a,
  input  logic [FA16_W-1:0] in_b,
  input  logic              in_c0,
  input  logic              in_z,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FA16_W-1:0] out_s,
  output logic              out_c15,
  output logic              out_err,
  output logic              dir,
  output logic [FA16_W-1:0] f_a,
  output logic [FA16_W-1:0] f_b,
  output logic              f_c0_f,
  output logic              f_z,
  input  logic [FA16_W-1:0] f_s,
  input  logic [FA16_W-1:0] f_a_b,
  input  logic              f_c0_b,
  input  logic              f_c15,
  output logic [FA16_W-1:0] r_s,
  output logic [FA16_W-1:0] r_a_b,
  output logic              r_c0_b,
  output logic              r_c15,
  input  logic [FA16_W-1:0] r_a,
  input  logic [FA16_W-1:0] r_b,
  input  logic              r_c0_f,
  input  logic              r_z
);

  generate
    if (SETTLE < 1) begin : g_bad_settle
      $error("fa16_rev_seq: SETTLE must be at least 1");
    end
  endgenerate

  localparam int CW = $clog2(SETTLE + 1);
  localparam logic [CW-1:0] LOAD = CW'(SETTLE - 1);

  fa16_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  fa16_opnd_t opnd_q, opnd_d;
  fa16_res_t res_q, res_d;
  logic dir_q, dir_d;
  logic fwd_err_q, fwd_err_d;
  logic out_valid_q, out_valid_d;
  logic out_err_q, out_err_d;
  fa16_opnd_t rec;
  logic mismatch;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    opnd_d      = opnd_q;
    res_d       = res_q;
    dir_d       = dir_q;
    fwd_err_d   = fwd_err_q;
    out_valid_d = out_valid_q;
    out_err_d   = out_err_q;
    rec.a       = r_a;
    rec.b       = r_b;
    rec.c0      = r_c0_f;
    rec.z       = r_z;
    mismatch    = (rec != opnd_q);
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          opnd_d.a  = in_a;
          opnd_d.b  = in_b;
          opnd_d.c0 = in_c0;
          opnd_d.z  = in_z;
          cnt_d     = LOAD;
          state_d   = FWD;
        end
      end
      FWD: begin
        if (cnt_q == '0) begin
          res_d.s    = f_s;
          res_d.a_b  = f_a_b;
          res_d.c0_b = f_c0_b;
          res_d.c15  = f_c15;
          fwd_err_d  = (f_a_b != opnd_q.a);
          cnt_d      = LOAD;
          // result capture and dir flip share this edge
          dir_d      = 1'b1;
          state_d    = BWD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      BWD: begin
        if (cnt_q == '0) begin
          out_err_d   = fwd_err_q | mismatch;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          dir_d       = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      opnd_q      <= '0;
      res_q       <= '0;
      dir_q       <= 1'b0;
      fwd_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      opnd_q      <= opnd_d;
      res_q       <= res_d;
      dir_q       <= dir_d;
      fwd_err_q   <= fwd_err_d;
      out_valid_q <= out_valid_d;
      out_err_q   <= out_err_d;
    end
  end

  assign in_ready  = (state_q == IDLE) & ~rst;
  assign out_valid = out_valid_q;
  assign out_s     = res_q.s;
  assign out_c15   = res_q.c15;
  assign out_err   = out_err_q;
  assign dir       = dir_q;
  assign f_a       = opnd_q.a;
  assign f_b       = opnd_q.b;
  assign f_c0_f    = opnd_q.c0;
  assign f_z       = opnd_q.z;
  assign r_s       = res_q.s;
  assign r_a_b     = res_q.a_b;
  assign r_c0_b    = res_q.c0_b;
  assign r_c15     = res_q.c15;

endmodule

// File: tb/tb_fa16_rev_seq.sv
// Bench for fa16_rev_seq: two instances (SETTLE=2 and SETTLE=1), each
// attached to a behavioural reversible adder.
module tb_fa16_rev_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [15:0] in_a, in_b;
  logic in_c0, in_z, out_ready;
  logic v2, v1, flip2;

  int vec = 0;
  int bad = 0;

  // SETTLE=2 instance and its adder
  logic rdy2, ov2, oc2, oe2, dir2;
  logic [15:0] os2, fa2, fb2, fs2, fab2, rs2, rab2, ra2, rb2;
  logic fc02, fz2, fc0b2, fc152, rc0b2, rc152, rc0f2, rz2;
  logic [16:0] fsum2, bsum2;
  logic [15:0] rbt2;

  assign fsum2 = {1'b0, fa2} + {1'b0, fb2} + {16'd0, fc02};
  assign fs2   = fsum2[15:0];
  assign fab2  = fa2;
  assign fc0b2 = fc02;
  assign fc152 = fsum2[16] ^ fz2;
  assign rbt2  = rs2 - rab2 - {15'd0, rc0b2};
  assign bsum2 = {1'b0, rab2} + {1'b0, rbt2} + {16'd0, rc0b2};
  assign ra2   = rab2;
  assign rb2   = rbt2 ^ (flip2 ? 16'h0008 : 16'h0000);
  assign rc0f2 = rc0b2;
  assign rz2   = rc152 ^ bsum2[16];

  fa16_rev_seq #(.SETTLE(2)) u_dut2 (
    .clk(clk), .rst(rst),
    .in_valid(v2), .in_ready(rdy2),
    .in_a(in_a), .in_b(in_b), .in_c0(in_c0), .in_z(in_z),
    .out_valid(ov2), .out_ready(out_ready),
    .out_s(os2), .out_c15(oc2), .out_err(oe2), .dir(dir2),
    .f_a(fa2), .f_b(fb2), .f_c0_f(fc02), .f_z(fz2),
    .f_s(fs2), .f_a_b(fab2), .f_c0_b(fc0b2), .f_c15(fc152),
    .r_s(rs2), .r_a_b(rab2), .r_c0_b(rc0b2), .r_c15(rc152),
    .r_a(ra2), .r_b(rb2), .r_c0_f(rc0f2), .r_z(rz2)
  );

  // SETTLE=1 instance and its adder
  logic rdy1, ov1, oc1, oe1, dir1;
  logic [15:0] os1, fa1, fb1, fs1, fab1, rs1, rab1, ra1, rb1;
  logic fc01, fz1, fc0b1, fc151, rc0b1, rc151, rc0f1, rz1;
  logic [16:0] fsum1, bsum1;

  assign fsum1 = {1'b0, fa1} + {1'b0, fb1} + {16'd0, fc01};
  assign fs1   = fsum1[15:0];
  assign fab1  = fa1;
  assign fc0b1 = fc01;
  assign fc151 = fsum1[16] ^ fz1;
  assign ra1   = rab1;
  assign rb1   = rs1 - rab1 - {15'd0, rc0b1};
  assign bsum1 = {1'b0, rab1} + {1'b0, rb1} + {16'd0, rc0b1};
  assign rc0f1 = rc0b1;
  assign rz1   = rc151 ^ bsum1[16];

  fa16_rev_seq #(.SETTLE(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .in_valid(v1), .in_ready(rdy1),
    .in_a(in_a), .in_b(in_b), .in_c0(in_c0), .in_z(in_z),
    .out_valid(ov1), .out_ready(out_ready),
    .out_s(os1), .out_c15(oc1), .out_err(oe1), .dir(dir1),
    .f_a(fa1), .f_b(fb1), .f_c0_f(fc01), .f_z(fz1),
    .f_s(fs1), .f_a_b(fab1), .f_c0_b(fc0b1), .f_c15(fc151),
    .r_s(rs1), .r_a_b(rab1), .r_c0_b(rc0b1), .r_c15(rc151),
    .r_a(ra1), .r_b(rb1), .r_c0_f(rc0f1), .r_z(rz1)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        c0;
    logic [15:0] s;
    logic        c;
    logic        e;
    logic        flip;
  } vec_t;

  vec_t tbl[7];
  logic dirlog[0:31];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // one operand through the SETTLE=2 instance; lat counts cycles to out_valid
  task automatic op2(input logic [15:0] a, input logic [15:0] b,
                     input logic c0, output logic [15:0] s,
                     output logic c, output logic e, output int lat);
    int n;
    n = 0;
    while (!rdy2 && n < 20) begin
      step();
      n++;
    end
    chk("op2_ready_timeout", 32'(n >= 20), 0);
    in_a = a; in_b = b; in_c0 = c0; in_z = 1'b0;
    v2 = 1'b1;
    dirlog[0] = dir2;
    step();
    v2 = 1'b0;
    lat = 1;
    dirlog[1] = dir2;
    while (!ov2 && lat < 30) begin
      step();
      lat++;
      dirlog[lat] = dir2;
    end
    chk("op2_valid_timeout", 32'(lat >= 30), 0);
    s = os2; c = oc2; e = oe2;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] s;
    logic c, e;
    int lat, n, cyc, iss, rcv, last;
    logic [16:0] q[$];
    logic [16:0] ex;

    tbl[0] = '{16'h1234, 16'h0FF0, 1'b0, 16'h2224, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b1, 1'b1};
    tbl[3] = '{16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{16'h00FF, 16'h0F01, 1'b1, 16'h1001, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};

    rst = 1'b1;
    in_a = '0; in_b = '0; in_c0 = 1'b0; in_z = 1'b0;
    out_ready = 1'b0; v2 = 1'b0; v1 = 1'b0; flip2 = 1'b0;
    step();
    step();
    chk("rst_out_valid", ov2, 0);
    chk("rst_out_err", oe2, 0);
    chk("rst_out_s", os2, 0);
    chk("rst_out_c15", oc2, 0);
    chk("rst_dir", dir2, 0);
    chk("rst_f_a", fa2, 0);
    chk("rst_r_s", rs2, 0);
    chk("rst_in_ready", rdy2, 0);
    rst = 1'b0;
    step();
    chk("idle_in_ready", rdy2, 1);

    foreach (tbl[i]) begin
      flip2 = tbl[i].flip;
      op2(tbl[i].a, tbl[i].b, tbl[i].c0, s, c, e, lat);
      flip2 = 1'b0;
      chk($sformatf("tbl%0d_s", i), s, tbl[i].s);
      chk($sformatf("tbl%0d_c15", i), c, tbl[i].c);
      chk($sformatf("tbl%0d_err", i), e, tbl[i].e);
      chk($sformatf("tbl%0d_lat", i), lat, 5);
      if (i == 0) begin
        chk("t1_dir_T1", dirlog[1], 0);
        chk("t1_dir_T2", dirlog[2], 0);
        chk("t1_dir_T3", dirlog[3], 1);
        chk("t1_dir_T4", dirlog[4], 1);
      end
    end

    // DONE held with out_ready low, new operand pending
    in_a = 16'h00FF; in_b = 16'h0101; in_c0 = 1'b0;
    v2 = 1'b1;
    step();
    v2 = 1'b0;
    n = 0;
    while (!ov2 && n < 20) begin
      step();
      n++;
    end
    chk("hold_timeout", 32'(n >= 20), 0);
    in_a = 16'h0300; in_b = 16'h0004;
    v2 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("hold_valid", ov2, 1);
      chk("hold_s", os2, 16'h0200);
      chk("hold_c15", oc2, 0);
      chk("hold_err", oe2, 0);
      chk("hold_in_ready", rdy2, 0);
      step();
    end
    out_ready = 1'b1;
    chk("hs_in_ready", rdy2, 0);
    step();
    out_ready = 1'b0;
    chk("post_hs_valid", ov2, 0);
    chk("post_hs_in_ready", rdy2, 1);
    step();
    v2 = 1'b0;
    chk("pending_taken", rdy2, 0);
    n = 0;
    while (!ov2 && n < 20) begin
      step();
      n++;
    end
    chk("pending_timeout", 32'(n >= 20), 0);
    chk("pending_s", os2, 16'h0304);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // reset in the second BWD cycle
    in_a = 16'h5555; in_b = 16'h0001; in_c0 = 1'b0;
    v2 = 1'b1;
    step();
    v2 = 1'b0;
    step();
    step();
    step();
    chk("abort_pre_dir", dir2, 1);
    rst = 1'b1;
    #1;
    chk("abort_dir", dir2, 0);
    chk("abort_valid", ov2, 0);
    chk("abort_in_ready", rdy2, 0);
    step();
    step();
    rst = 1'b0;
    n = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (ov2) n++;
    end
    chk("abort_no_stale", n, 0);
    op2(16'h0010, 16'h0020, 1'b0, s, c, e, lat);
    chk("abort_new_s", s, 16'h0030);
    chk("abort_new_err", e, 0);

    // random operands through SETTLE=2
    for (int k = 0; k < 20; k++) begin
      logic [15:0] a, b;
      logic ci;
      a = 16'($urandom);
      b = 16'($urandom);
      ci = 1'($urandom_range(0, 1));
      ex = {1'b0, a} + {1'b0, b} + {16'd0, ci};
      op2(a, b, ci, s, c, e, lat);
      chk("rnd2_sum", {c, s}, ex);
      chk("rnd2_err", e, 0);
    end

    // SETTLE=1 back-to-back with out_ready held high
    out_ready = 1'b1;
    cyc = 0; iss = 0; rcv = 0; last = 0;
    while (rcv < 100 && cyc < 2000) begin
      if (ov1) begin
        if (q.size() > 0) begin
          ex = q.pop_front();
          chk("b2b_sum", {oc1, os1}, ex);
          chk("b2b_err", oe1, 0);
        end else begin
          chk("b2b_unexpected", 1, 0);
        end
        rcv++;
      end
      if (rdy1 && iss < 100) begin
        in_a = 16'($urandom);
        in_b = 16'($urandom);
        in_c0 = 1'($urandom_range(0, 1));
        in_z = 1'b0;
        q.push_back({1'b0, in_a} + {1'b0, in_b} + {16'd0, in_c0});
        if (iss > 0) chk("b2b_interval", cyc - last, 4);
        last = cyc;
        iss++;
        v1 = 1'b1;
      end else begin
        v1 = 1'b0;
      end
      step();
      cyc++;
    end
    chk("b2b_count", rcv, 100);
    out_ready = 1'b0;
    v1 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
